// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master engine.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_DATA,
    RSP
  } ame_state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_engine_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_master_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_watchdog.sv
// Saturating wait-cycle counter with a sticky flag raised when the count
// reaches TIMEOUT_CYCLES-1.
module axi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  input  logic flag_clear,
  output logic flag
);
  // TIMEOUT_CYCLES-1 always fits in clog2(TIMEOUT_CYCLES) bits for values >= 2.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] count_reg;
  logic             flag_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
      flag_reg  <= 1'b0;
    end else begin
      if (clear)
        count_reg <= '0;
      else if (enable && count_reg != CNT_MAX)
        count_reg <= count_reg + CNT_W'(1);

      // Flag rises on the same edge the count lands on CNT_MAX.
      if (flag_clear)
        flag_reg <= 1'b0;
      else if (!clear && enable && count_reg == CNT_PRE)
        flag_reg <= 1'b1;
    end
  end

  assign flag = flag_reg;

endmodule

// File: rtl/axi_lite_master_engine.sv
// Command/response stream to single AXI4-Lite transactions, one outstanding,
// with a watchdog that flags a stalled slave channel.
module axi_lite_master_engine
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          stall_flag,
  axi_lite_master_engine_if.master      m_axi
);

  ame_state_t state_reg, state_next;
  logic aw_done_reg, aw_done_next;
  logic w_done_reg, w_done_next;

  logic                          write_reg;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_reg;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_reg;

  logic cmd_ready_reg, awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
  logic rsp_valid_reg;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_reg;
  axi_resp_t rsp_resp_reg;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs = cmd_valid && cmd_ready_reg;
  assign aw_hs  = awvalid_reg && m_axi.awready;
  assign w_hs   = wvalid_reg && m_axi.wready;
  assign b_hs   = bready_reg && m_axi.bvalid;
  assign ar_hs  = arvalid_reg && m_axi.arready;
  assign r_hs   = rready_reg && m_axi.rvalid;
  assign rsp_hs = rsp_valid_reg && rsp_ready;

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_hs) begin
          state_next   = cmd_write ? WR_ISSUE : RD_ISSUE;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      WR_ISSUE: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP:  if (b_hs)   state_next = RSP;
      RD_ISSUE: if (ar_hs)  state_next = RD_DATA;
      RD_DATA:  if (r_hs)   state_next = RSP;
      RSP:      if (rsp_hs) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so no input reaches
  // an output combinationally.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_reg     <= IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      cmd_ready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= OKAY;
    end else begin
      state_reg     <= state_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      cmd_ready_reg <= (state_next == IDLE);
      awvalid_reg   <= (state_next == WR_ISSUE) && !aw_done_next;
      wvalid_reg    <= (state_next == WR_ISSUE) && !w_done_next;
      bready_reg    <= (state_next == WR_RESP);
      arvalid_reg   <= (state_next == RD_ISSUE);
      rready_reg    <= (state_next == RD_DATA);
      rsp_valid_reg <= (state_next == RSP);
      if (cmd_hs) begin
        write_reg <= cmd_write;
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
        wstrb_reg <= cmd_write ? cmd_wstrb : '0;
      end
      if (b_hs) begin
        rsp_rdata_reg <= '0;
        rsp_resp_reg  <= axi_resp_t'(m_axi.bresp);
      end
      if (r_hs) begin
        rsp_rdata_reg <= m_axi.rdata;
        rsp_resp_reg  <= axi_resp_t'(m_axi.rresp);
      end
    end
  end

  axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (axi_aclk),
    .srst       (axi_areset),
    .clear      ((state_next != state_reg) || aw_hs || w_hs),
    .enable     ((state_reg == WR_ISSUE) || (state_reg == WR_RESP) ||
                 (state_reg == RD_ISSUE) || (state_reg == RD_DATA)),
    .flag_clear (cmd_hs),
    .flag       (stall_flag)
  );

  assign cmd_ready     = cmd_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_write     = write_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;

  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awprot  = AXI_PROT_DEFAULT;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = wstrb_reg;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arprot  = AXI_PROT_DEFAULT;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

endmodule

// File: doc/axi_lite_master_engine.md
# axi_lite_master_engine

Synthesisable AXI4-Lite master that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions and returns the result on a response stream. It replaces hand-written bus sequencing with RTL, so an on-chip sequencer or self-test controller can program and read back the hdmi_text_controller VRAM and control register. Address and data widths are parametrised, and per-byte strobes are passed through. A watchdog flags a slave that stalls any channel. One transaction is outstanding at a time.

## Interface
- C_AXI_DATA_WIDTH, 32, data width in bits; must be 32 or 64.
- C_AXI_ADDR_WIDTH, 16, byte-address width in bits.
- TIMEOUT_CYCLES, 1024, number of wait cycles on any AXI channel before `stall_flag` sets; must be at least 2.
- axi_aclk  in  1  the single clock.
- axi_areset  in  1  reset; synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 selects write, 0 selects read.
- cmd_addr  in  C_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_AXI_DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_write  out  1  echoes `cmd_write`.
- rsp_rdata  out  C_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- stall_flag  out  1  sticky watchdog flag.
- axi_awaddr, axi_awprot, axi_awvalid, axi_awready; axi_wdata, axi_wstrb, axi_wvalid, axi_wready; axi_bresp, axi_bvalid, axi_bready; axi_araddr, axi_arprot, axi_arvalid, axi_arready; axi_rdata, axi_rresp, axi_rvalid, axi_rready — standard AXI4-Lite widths and directions. `axi_awprot` and `axi_arprot` are tied to 3'b000.

## Operation
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, RSP.
- IDLE: `cmd_ready`=1 here and in no other state. On a command handshake, latch all command fields and go to WR_ISSUE (`cmd_write`=1) or RD_ISSUE (`cmd_write`=0).
- WR_ISSUE:
  - `axi_awvalid` and `axi_wvalid` both assert.
  - Each valid drops on the edge that completes its own handshake. Completion is tracked separately by `aw_done` and `w_done`.
  - AW and W may complete in the same cycle or in either order.
  - Move to WR_RESP once both are done.
- WR_RESP: `axi_bready`=1. On the B handshake, capture `axi_bresp`, set `rsp_rdata`=0, go to RSP.
- RD_ISSUE: `axi_arvalid`=1 until the AR handshake, then go to RD_DATA.
- RD_DATA: `axi_rready`=1. On the R handshake, capture `axi_rdata` and `axi_rresp`, go to RSP.
- RSP: `rsp_valid`=1 and held stable until `rsp_ready`, then go to IDLE.
- A valid is never withdrawn before its handshake; the master never aborts a transaction.
- Watchdog:
  - The counter clears on every state change and on every AW or W handshake.
  - It increments each cycle spent in WR_ISSUE, WR_RESP, RD_ISSUE or RD_DATA. It does not count in RSP.
  - When the count equals TIMEOUT_CYCLES-1, `stall_flag` sets. The counter saturates there.
  - `stall_flag` clears only on reset or on the next accepted command.
- An error response (SLVERR or DECERR) is reported in `rsp_resp` only; it does not affect state flow.

## Timing
- Reset values: all AXI valid and ready outputs 0, `cmd_ready`=0 during reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=0, `stall_flag`=0, state IDLE. `cmd_ready` rises the first cycle after reset deasserts.
- Reset asserted mid-transaction: all outputs return to their reset values on that edge. The in-flight transaction is dropped and no response is produced.
- Cycle numbering (edge n = end of cycle n):
  - Command accepted on edge 0.
  - AXI valids are high in cycle 1.
  - With a zero-wait slave, AW/W (or AR) complete on edge 1.
  - `bready`/`rready` are high in cycle 2 and B/R completes on edge 2.
  - `rsp_valid` is high in cycle 3. Minimum command-to-response latency is 3 cycles.
- Back-to-back: a response handshake at edge k returns the engine to IDLE; the next command can be accepted on edge k+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `axi_lite_pkg` holds:
  - `axi_resp_t` enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - `ame_state_t` state enum.
  - `AXI_PROT_DEFAULT`=3'b000.
- One sub-module, `axi_watchdog`: parametrised saturating counter with `clear`, `enable` and a sticky flag.

## Test plan
- Write 0x0960 ← 0x001F6000, strb 0xF, to a zero-wait slave → `rsp_valid` in cycle 3, `rsp_resp`=0, slave register reads back 0x001F6000.
- Slave asserts `wready` 2 cycles before `awready` → `wvalid` drops after the W handshake, `awvalid` holds until its own handshake, exactly one B handshake, one response.
- Loop of 600 writes (addr 4*i, data i) then 600 reads → every `rsp_rdata`==i, `stall_flag` stays 0.
- Write strb 0x2, data 0xAABBCCDD, over old value 0x11223344 → readback 0x1122CC44.
- Slave holds `arready`=0 for 1100 cycles with TIMEOUT_CYCLES=1024 → `stall_flag`=1 at the 1024th wait cycle, `arvalid` stays high, read completes normally afterwards, next command clears `stall_flag`.
- Reset pulsed while in WR_RESP → next cycle all valids 0, `rsp_valid`=0, state IDLE; a subsequent read returns OKAY.
